// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed common-anode 7-segment driver with per-frame digit snapshot.
// Latency : outputs are registered and reflect the state after each enabled clk edge.
// Backpr. : none; en low freezes prescaler, digit index, shadows and outputs.
//
// Ports:
//   clk   - clock
//   rst   - synchronous reset, active-low (priority over en)
//   en    - advance enable
//   bcd   - DIGITS packed BCD digits, digit 0 in bcd[3:0] (least significant)
//   dp    - per-digit decimal point request, active-high
//   an    - anode enables, active-low, registered
//   seg   - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n  - decimal point, active-low, registered
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown). Without it every digit decodes normally.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DIV_WIDTH = 16,
  parameter int IDX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n
);

  localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DIGITS - 1);

  logic [DIV_WIDTH-1:0] cnt, cnt_nx;
  logic [IDX_WIDTH-1:0] idx, idx_nx;
  logic [4*DIGITS-1:0]  bcd_s, bcd_nx;
  logic [DIGITS-1:0]    dp_s, dp_nx;
  logic                 snap;

  logic [3:0]           digit;
  logic                 dp_sel;
  logic [DIGITS-1:0]    an_nx;
  logic [6:0]           seg_nx;
  logic                 dpn_nx;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;  // non-BCD codes show a dash
    endcase
  endfunction

  // Next prescaler / index state and frame-start snapshot.
  always_comb begin
    cnt_nx = cnt + 1'b1;
    idx_nx = idx;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    // Capture only at the very start of a frame so a frame never mixes
    // digits from two different counter values.
    snap   = (cnt == '0) && (idx == '0);
    bcd_nx = snap ? bcd : bcd_s;
    dp_nx  = snap ? dp  : dp_s;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              blank_sel;
  logic              run_zero;

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    blank    = '0;
    run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero = run_zero && (bcd_nx[4*i +: 4] == 4'd0);
      blank[i] = run_zero;
    end
  end
`endif

  // Outputs are a function of the post-edge state so the registered
  // outputs line up with the state registers on the same edge.
  always_comb begin
    digit  = '0;
    dp_sel = 1'b0;
    an_nx  = '1;
`ifdef LEADING_ZERO_BLANK_EN
    blank_sel = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nx == IDX_WIDTH'(i)) begin
        digit    = bcd_nx[4*i +: 4];
        dp_sel   = dp_nx[i];
        an_nx[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank_sel = blank[i];
`endif
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    seg_nx = blank_sel ? 7'b1111111 : decode(digit);
`else
    seg_nx = decode(digit);
`endif
    dpn_nx = ~dp_sel;
    // First cycle of each slot is a guard with every anode off, which
    // hides ghosting while the segment lines switch between digits.
    if (cnt_nx == '0) begin
      an_nx  = '1;
      seg_nx = 7'b1111111;
      dpn_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      bcd_s <= '0;
      dp_s  <= '0;
      an    <= '1;
      seg   <= 7'b1111111;
      dp_n  <= 1'b1;
    end else if (en) begin
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      bcd_s <= bcd_nx;
      dp_s  <= dp_nx;
      an    <= an_nx;
      seg   <= seg_nx;
      dp_n  <= dpn_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4).
// Latency : one expected output word per driven edge, compared 1 time unit after the edge.
// Backpr. : n/a; stimulus is a fixed sequence of frames.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DIV_WIDTH(16), .IDX_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp(dp),
    .an(an), .seg(seg), .dp_n(dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs {an, seg, dp_n}
  logic [11:0] exp_q [$];

  logic [6:0] dec_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  // Reference state: position within the frame plus the shadows.
  int          m_pos;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [11:0] m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [15:0] b, input logic [3:0] d);
    int slot;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    if (!r) begin
      m_pos = 0;
      m_bcd = '0;
      m_dp  = '0;
      m_out = {4'b1111, 7'b1111111, 1'b1};
    end else if (e) begin
      if (m_pos == 0) begin
        m_bcd = b;
        m_dp  = d;
      end
      m_pos = (m_pos + 1) % FRAME;
      slot  = m_pos / SCAN_DIV;
      if (m_pos % SCAN_DIV == 0) begin
        m_out = {4'b1111, 7'b1111111, 1'b1};
      end else begin
        an_e  = 4'b1111;
        an_e[slot] = 1'b0;
        seg_e = dec_tab[(m_bcd >> (4 * slot)) & 16'hF];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot >= 1 && (m_bcd >> (4 * slot)) == 16'h0) seg_e = 7'b1111111;
`endif
        m_out = {an_e, seg_e, ~m_dp[slot]};
      end
    end
  endtask

  // Drive one edge, push the model's expectation, then pop and compare.
  task automatic step(input logic r, input logic e, input logic [15:0] b, input logic [3:0] d);
    logic [11:0] exp;
    @(negedge clk);
    rst = r; en = e; bcd = b; dp = d;
    model_edge(r, e, b, d);
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk("sb_an",   an,   exp[11:8]);
      chk("sb_seg",  seg,  exp[7:1]);
      chk("sb_dp_n", dp_n, exp[0]);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; bcd = '0; dp = '0;
    m_pos = 0; m_bcd = '0; m_dp = '0; m_out = '1;

    // Reset held for three edges with en high.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 16'h1234, 4'b0000);
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_dpn", dp_n, 1'b1);
    end

    // Scan order, two frames of 1234.
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(1'b1, 1'b1, 16'h1234, 4'b0000);
      if (k == 0) begin chk("scan_e0_an", an, 4'b1110); chk("scan_e0_seg", seg, 7'b0011001); end
      if (k == 3) chk("scan_e3_guard", an, 4'b1111);
      if (k == 4) begin chk("scan_e4_an", an, 4'b1101); chk("scan_e4_seg", seg, 7'b0110000); end
      if (k == 8) begin chk("scan_e8_an", an, 4'b1011); chk("scan_e8_seg", seg, 7'b0100100); end
      if (k == 12) begin chk("scan_e12_an", an, 4'b0111); chk("scan_e12_seg", seg, 7'b1111001); end
      if (k == 15) chk("scan_wrap_guard", an, 4'b1111);
      if (k == 16) chk("scan_wrap_an", an, 4'b1110);
    end

    // Snapshot coherence: bcd changes during the digit-1 slot.
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, 1'b1, (k >= 5) ? 16'h9999 : 16'h1234, 4'b0000);
      if (k == 8)  chk("coh_digit2", seg, 7'b0100100);
      if (k == 12) chk("coh_digit3", seg, 7'b1111001);
    end
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, 1'b1, 16'h9999, 4'b0000);
      if (k == 0) chk("coh_new_d0", seg, 7'b0010000);
    end

    // Invalid code with decimal point, then freeze and reset mid-frame.
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b1, 16'h000A, 4'b0001);
      if (k == 0) begin chk("inv_seg", seg, 7'b0111111); chk("inv_dpn", dp_n, 1'b0); end
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 16'h5555, 4'b1111);
      chk("frz_an", an, 4'b1011);
    end
    step(1'b1, 1'b1, 16'h5555, 4'b1111);  // resumes from the held count
    step(1'b0, 1'b1, 16'h5555, 4'b1111);
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_seg", seg, 7'b1111111);

    // Leading-zero handling with 0007.
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, 1'b1, 16'h0007, 4'b0000);
      if (k == 0) begin chk("lz_restart_an", an, 4'b1110); chk("lz_d0", seg, 7'b1111000); end
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 4 || k == 8 || k == 12) chk("lz_blank", seg, 7'b1111111);
`else
      if (k == 4 || k == 8 || k == 12) chk("lz_zero", seg, 7'b1000000);
`endif
    end

    // Randomised stretch with occasional en drops and data changes.
    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           16'($urandom()), 4'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
